// File: rtl/ctrl_defs.sv
// ctrl_defs: shared state encodings, opcodes and ALU codes for the multicycle controller
package ctrl_defs;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: funct3/funct7b5 to ALU operation for register and immediate ALU instructions
module alu_decoder
  import ctrl_defs::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       is_r,
  output logic [2:0] alu_control
);
  always_comb
    alu_control = (funct3 == 3'b000) ? ((is_r && funct7b5) ? ALU_SUB : ALU_ADD) :
                  (funct3 == 3'b010) ? ALU_SLT :
                  (funct3 == 3'b110) ? ALU_OR  :
                  (funct3 == 3'b111) ? ALU_AND : ALU_ADD;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM control unit for a multicycle RV32 subset datapath
// Optional retired-instruction counter output enabled by defining CTRL_INSTRET_EN.
module multicycle_controller
  import ctrl_defs::*;
#(
  parameter int BUS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           imm_src,
  output logic [2:0]           alu_control
`ifdef CTRL_INSTRET_EN
  ,
  output logic [BUS_WIDTH-1:0] instret
`endif
);
  state_t     state, state_next;
  logic       pc_update, branch, ir_w, mem_w, reg_w;
  logic [2:0] dec_ctl;
  if (BUS_WIDTH < 1) begin : g_bad_width
    $error("BUS_WIDTH must be at least 1");
  end
  alu_decoder u_alu_decoder (
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .is_r       (state == S_EXECUTER),
    .alu_control(dec_ctl)
  );
  always_ff @(posedge clk)
    state <= rst_n ? state_next : S_FETCH;
  always_comb begin
    state_next  = S_FETCH;
    pc_update   = 1'b0;
    branch      = 1'b0;
    ir_w        = 1'b0;
    mem_w       = 1'b0;
    reg_w       = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    case (state)
      S_FETCH: begin
        ir_w = 1'b1;
        alu_src_b = 2'b10;
        result_src = 2'b10;
        pc_update = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        state_next = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                     (op == OP_R)   ? S_EXECUTER :
                     (op == OP_I)   ? S_EXECUTEI :
                     (op == OP_JAL) ? S_JAL :
                     (op == OP_BEQ) ? S_BEQ : S_FETCH;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_w = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_control = dec_ctl;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_control = dec_ctl;
        state_next = S_ALUWB;
      end
      S_ALUWB: reg_w = 1'b1;
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_next = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_control = ALU_SUB;
        branch = 1'b1;
      end
      default: ;
    endcase
  end
  // Write enables are gated by reset so an interrupted instruction cannot commit.
  always_comb begin
    pc_write  = rst_n & (pc_update | (branch & zero));
    mem_write = rst_n & mem_w;
    ir_write  = rst_n & ir_w;
    reg_write = rst_n & reg_w;
    imm_src   = (op == OP_SW)  ? 2'b01 :
                (op == OP_BEQ) ? 2'b10 :
                (op == OP_JAL) ? 2'b11 : 2'b00;
  end
`ifdef CTRL_INSTRET_EN
  logic retire;
  always_comb
    retire = (state_next == S_FETCH) &&
             (state == S_MEMWB || state == S_MEMWRITE || state == S_ALUWB ||
              state == S_BEQ || state == S_DECODE);
  always_ff @(posedge clk)
    if (!rst_n) instret <= '0;
    else if (retire) instret <= instret + 1'b1;
`endif
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed checks of the multicycle controller FSM
module tb_multicycle_controller;
  import ctrl_defs::*;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  int total = 0;
  int bad = 0;
`ifdef CTRL_INSTRET_EN
  logic [31:0] instret;
  logic        rst2_n;
  logic        pc_write2, adr_src2, mem_write2, ir_write2, reg_write2;
  logic [1:0]  result_src2, alu_src_a2, alu_src_b2, imm_src2, instret2;
  logic [2:0]  alu_control2;
`endif
  always #5 clk = ~clk;
  multicycle_controller #(.BUS_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_control(alu_control)
`ifdef CTRL_INSTRET_EN
    , .instret(instret)
`endif
  );
`ifdef CTRL_INSTRET_EN
  multicycle_controller #(.BUS_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .op(7'b1111111), .funct3(3'b000), .funct7b5(1'b0), .zero(1'b0),
    .pc_write(pc_write2), .adr_src(adr_src2), .mem_write(mem_write2), .ir_write(ir_write2),
    .reg_write(reg_write2), .result_src(result_src2), .alu_src_a(alu_src_a2),
    .alu_src_b(alu_src_b2), .imm_src(imm_src2), .alu_control(alu_control2), .instret(instret2)
  );
`endif
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
`ifdef CTRL_INSTRET_EN
    rst2_n = 1'b0;
`endif
    rst_n = 1'b0; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; zero = 1'b0;
    step(); step();
    chk("rst_state", 32'(dut.state), 32'(S_FETCH));
    chk("rst_irw", 32'(ir_write), 0);
    chk("rst_pcw", 32'(pc_write), 0);
    rst_n = 1'b1;
    op = OP_LW;
    #1;
    chk("fetch_irw", 32'(ir_write), 1);
    chk("fetch_pcw", 32'(pc_write), 1);
    chk("fetch_srcb", 32'(alu_src_b), 2);
    chk("fetch_res", 32'(result_src), 2);
    // lw: FETCH DECODE MEMADR MEMREAD MEMWB
    step();
    chk("lw_dec_state", 32'(dut.state), 32'(S_DECODE));
    chk("lw_dec_srca", 32'(alu_src_a), 1);
    chk("lw_dec_rw", 32'(reg_write), 0);
    step();
    chk("lw_adr_state", 32'(dut.state), 32'(S_MEMADR));
    chk("lw_adr_srca", 32'(alu_src_a), 2);
    chk("lw_adr_rw", 32'(reg_write), 0);
    step();
    chk("lw_rd_adrsrc", 32'(adr_src), 1);
    chk("lw_rd_rw", 32'(reg_write), 0);
    step();
    chk("lw_wb_state", 32'(dut.state), 32'(S_MEMWB));
    chk("lw_wb_rw", 32'(reg_write), 1);
    chk("lw_wb_res", 32'(result_src), 1);
    step();
    chk("lw_done_state", 32'(dut.state), 32'(S_FETCH));
`ifdef CTRL_INSTRET_EN
    chk("lw_instret", instret, 1);
`endif
    // sw, then reset asserted while in MEMWRITE
    op = OP_SW;
    #1;
    chk("sw_imm", 32'(imm_src), 1);
    step(); step(); step();
    chk("sw_state", 32'(dut.state), 32'(S_MEMWRITE));
    chk("sw_mw", 32'(mem_write), 1);
    chk("sw_adrsrc", 32'(adr_src), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_mw", 32'(mem_write), 0);
    chk("midrst_pcw", 32'(pc_write), 0);
    chk("midrst_irw", 32'(ir_write), 0);
    chk("midrst_rw", 32'(reg_write), 0);
    step();
    chk("midrst_state", 32'(dut.state), 32'(S_FETCH));
    chk("midrst_irw2", 32'(ir_write), 0);
    step();
    rst_n = 1'b1;
    op = OP_BEQ;
    #1;
    chk("post_rst_state", 32'(dut.state), 32'(S_FETCH));
`ifdef CTRL_INSTRET_EN
    chk("rst_instret", instret, 0);
`endif
    // beq: 3 cycles, branch taken only with zero
    step();
    chk("beq_dec_state", 32'(dut.state), 32'(S_DECODE));
    chk("beq_imm", 32'(imm_src), 2);
    step();
    chk("beq_state", 32'(dut.state), 32'(S_BEQ));
    zero = 1'b1;
    #1;
    chk("beq_taken_pcw", 32'(pc_write), 1);
    chk("beq_alu", 32'(alu_control), 32'(ALU_SUB));
    zero = 1'b0;
    #1;
    chk("beq_nottaken_pcw", 32'(pc_write), 0);
    step();
    chk("beq_done_state", 32'(dut.state), 32'(S_FETCH));
    // R-type
    op = OP_R; funct3 = 3'b000; funct7b5 = 1'b1;
    step(); step();
    chk("r_state", 32'(dut.state), 32'(S_EXECUTER));
    chk("r_sub", 32'(alu_control), 32'(ALU_SUB));
    chk("r_srcb", 32'(alu_src_b), 0);
    funct7b5 = 1'b0;
    #1;
    chk("r_add", 32'(alu_control), 32'(ALU_ADD));
    funct3 = 3'b010;
    #1;
    chk("r_slt", 32'(alu_control), 32'(ALU_SLT));
    funct3 = 3'b110;
    #1;
    chk("r_or", 32'(alu_control), 32'(ALU_OR));
    funct3 = 3'b111;
    #1;
    chk("r_and", 32'(alu_control), 32'(ALU_AND));
    funct3 = 3'b100;
    #1;
    chk("r_other", 32'(alu_control), 32'(ALU_ADD));
    step();
    chk("r_aluwb_rw", 32'(reg_write), 1);
    step();
    chk("r_done_state", 32'(dut.state), 32'(S_FETCH));
    // I-type: funct7b5 must not select sub
    op = OP_I; funct3 = 3'b000; funct7b5 = 1'b1;
    step(); step();
    chk("i_state", 32'(dut.state), 32'(S_EXECUTEI));
    chk("i_add", 32'(alu_control), 32'(ALU_ADD));
    chk("i_srcb", 32'(alu_src_b), 1);
    step(); step();
    chk("i_done_state", 32'(dut.state), 32'(S_FETCH));
    // jal
    op = OP_JAL;
    step(); step();
    chk("jal_state", 32'(dut.state), 32'(S_JAL));
    chk("jal_pcw", 32'(pc_write), 1);
    chk("jal_srcb", 32'(alu_src_b), 2);
    chk("jal_imm", 32'(imm_src), 3);
    step();
    chk("jal_aluwb", 32'(dut.state), 32'(S_ALUWB));
    step();
    chk("jal_done_state", 32'(dut.state), 32'(S_FETCH));
    // illegal op: 2 cycles, no writes
    op = 7'b1111111;
    #1;
    chk("ill_imm", 32'(imm_src), 0);
    step();
    chk("ill_dec_rw", 32'(reg_write), 0);
    chk("ill_dec_mw", 32'(mem_write), 0);
    step();
    chk("ill_done_state", 32'(dut.state), 32'(S_FETCH));
`ifdef CTRL_INSTRET_EN
    chk("instret_count", instret, 5);
    // narrow counter: three 2-cycle NOPs reach all-ones, one more wraps
    rst2_n = 1'b1;
    #1;
    chk("w_rst", 32'(instret2), 0);
    repeat (6) step();
    chk("w_ones", 32'(instret2), 3);
    step(); step();
    chk("w_wrap", 32'(instret2), 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32, the width of the instret counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-004 SHALL have port op, input, 7, instr[6:0].
REQ-005 SHALL have port funct3, input, 3, instr[14:12].
REQ-006 SHALL have port funct7b5, input, 1, instr[30].
REQ-007 SHALL have port zero, input, 1, ALU zero flag.
REQ-008 SHALL have ports pc_write, adr_src, mem_write, ir_write and reg_write, each output, 1, the datapath write enables and address select.
REQ-009 SHALL have ports result_src, alu_src_a, alu_src_b and imm_src, each output, 2, the datapath mux selects.
REQ-010 SHALL have port alu_control, output, 3, ALU operation code (000 add, 001 sub, 010 and, 011 or, 101 slt).

Function
REQ-011 SHALL implement a Moore FSM with 4-bit state encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10; encodings 11-15 SHALL go to FETCH on the next edge.
REQ-012 SHALL use these transitions:
- FETCH->DECODE.
- DECODE: op 0000011/0100011->MEMADR; 0110011->EXECUTER; 0010011->EXECUTEI; 1101111->JAL; 1100011->BEQ; any other op->FETCH (NOP).
- MEMADR: op 0000011->MEMREAD, else->MEMWRITE.
- MEMREAD->MEMWB.
- EXECUTER, EXECUTEI and JAL->ALUWB.
- MEMWB, MEMWRITE, ALUWB and BEQ->FETCH.
REQ-013 SHALL drive outputs per state (a field not listed is 0):
- FETCH: ir_write=1, src_a=00, src_b=10, result_src=10, add, pc_update=1.
- DECODE: src_a=01, src_b=01, add.
- MEMADR: src_a=10, src_b=01, add.
- MEMREAD: adr_src=1.
- MEMWB: result_src=01, reg_write=1.
- MEMWRITE: adr_src=1, mem_write=1.
- EXECUTER: src_a=10, src_b=00, decoded op.
- EXECUTEI: src_a=10, src_b=01, decoded op.
- ALUWB: reg_write=1.
- JAL: src_a=01, src_b=10, add, pc_update=1.
- BEQ: src_a=10, src_b=00, sub, branch=1.
REQ-014 SHALL compute pc_write = pc_update | (branch & zero) combinationally.
REQ-015 SHALL decode imm_src combinationally from op in every state: 0100011->01, 1100011->10, 1101111->11, all others->00.
REQ-016 SHALL decode the ALU operation as follows in EXECUTER/EXECUTEI:
- funct3 000->sub if EXECUTER and funct7b5=1, else add.
- funct3 010->slt; 110->or; 111->and.
- any other funct3->add.
REQ-017 SHALL have per-instruction latency in cycles: lw 5; sw, R-type, I-ALU and jal 4; beq 3; illegal op 2.

Reset
REQ-018 SHALL load state FETCH on a rising clk edge while rst_n=0.
REQ-019 SHALL force pc_write, mem_write, ir_write and reg_write to 0 combinationally while rst_n=0, including when reset is asserted mid-instruction.
REQ-020 SHALL make the first FETCH effective on the first edge after rst_n returns to 1.

Configuration
REQ-021 With macro CTRL_INSTRET_EN defined, SHALL add output instret [BUS_WIDTH-1:0]:
- reset to 0;
- +1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB, BEQ or DECODE;
- wraps to 0 after all-ones.
REQ-022 Without CTRL_INSTRET_EN, SHALL have neither the instret port nor the counter logic.

Structure
REQ-023 SHALL place state encodings, opcode constants and alu_control codes in the shared ctrl_defs package/header.
REQ-024 SHALL implement the REQ-016 decode in a combinational sub-module alu_decoder.

Verification
REQ-025 Bench SHALL cover each directed scenario below.
- Reset: hold rst_n=0 for 2 cycles in state MEMWRITE -> all write enables 0; state=FETCH after the edge.
- lw (op 0000011) -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write=1 only in MEMWB; instret +1 after 5 cycles.
- beq: zero=1 -> pc_write=1 in BEQ; zero=0 -> pc_write=0; returns to FETCH after 3 cycles.
- R-type funct3=000: funct7b5=1 -> alu_control=001 in EXECUTER; funct7b5=0 -> 000; I-type funct3=000 with funct7b5=1 -> 000.
- Illegal op 1111111 -> FETCH, DECODE, FETCH; no reg_write/mem_write asserted.
- With CTRL_INSTRET_EN and instret forced to all-ones -> one retire wraps instret to 0.
